// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared encodings for the data-memory responder.
// Revision    : 1.0
// ============================================================================
package dmem_pkg;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  localparam int LATENCY_MAX = 15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/load_align.sv
`default_nettype none
// ============================================================================
// Module      : load_align
// Description : Extracts a byte/half/word lane and sign- or zero-extends it.
// Revision    : 1.0
// ============================================================================
module load_align
  import dmem_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_lane,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  output logic [31:0] o_result
);

  logic [31:0] w_shifted;

  always_comb begin
    w_shifted = i_word >> {i_lane, 3'b000};
    o_result  = 32'd0;
    case (i_size)
      SZ_WORD: o_result = i_word;
      SZ_HALF: o_result = {{16{~i_unsigned & w_shifted[15]}}, w_shifted[15:0]};
      SZ_BYTE: o_result = {{24{~i_unsigned & w_shifted[7]}}, w_shifted[7:0]};
      default: o_result = 32'd0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder
// Description : Req/Ack slave owning the data-memory array, with fixed latency.
// Revision    : 1.0
// ============================================================================
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int LATENCY     = 2,
  parameter int BYTE_ADDR_W = 32
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   Req,
  input  logic                   Write,
  input  logic [1:0]             Size,
  input  logic                   Unsigned,
  input  logic [BYTE_ADDR_W-1:0] Addr,
  input  logic [31:0]            WData,
  output logic                   Ack,
  output logic [31:0]            RData,
  output logic                   Err,
  output logic                   Busy
);

  // Out-of-range LATENCY values saturate into the 4-bit counter's legal range.
  localparam int c_lat = (LATENCY < 1) ? 1 :
                         (LATENCY > LATENCY_MAX) ? LATENCY_MAX : LATENCY;
  localparam logic [3:0] c_cnt_init = 4'(c_lat - 1);

  state_t                 r_state;
  logic [3:0]             r_cnt;
  logic                   r_write;
  logic [1:0]             r_size;
  logic                   r_unsigned;
  logic [BYTE_ADDR_W-1:0] r_addr;
  logic [31:0]            r_wdata;
  logic [31:0]            r_mem [2**ADDR_W];

  logic [ADDR_W-1:0]      w_idx;
  logic [1:0]             w_lane;
  logic [31:0]            w_rd_word;
  logic [31:0]            w_load_data;
  logic [31:0]            w_wdata_sh;
  logic [31:0]            w_merged;
  logic [3:0]             w_be;
  logic                   w_oor;
  logic                   w_err;
  logic                   w_access;

  assign w_idx      = r_addr[ADDR_W+1:2];
  assign w_lane     = r_addr[1:0];
  assign w_rd_word  = r_mem[w_idx];
  assign w_access   = (r_state == ST_WAIT) && (r_cnt == 4'd0);
  assign w_wdata_sh = r_wdata << {w_lane, 3'b000};

  if (BYTE_ADDR_W > ADDR_W + 2) begin : g_range_chk
    assign w_oor = |r_addr[BYTE_ADDR_W-1:ADDR_W+2];
  end else begin : g_no_range_chk
    assign w_oor = 1'b0;
  end

  assign w_err = (r_size == 2'b11)
               | ((r_size == SZ_HALF) & r_addr[0])
               | ((r_size == SZ_WORD) & (|r_addr[1:0]))
               | w_oor;

  always_comb begin
    w_be = 4'b0000;
    case (r_size)
      SZ_WORD: w_be = 4'b1111;
      SZ_HALF: w_be = 4'b0011 << w_lane;
      SZ_BYTE: w_be = 4'b0001 << w_lane;
      default: w_be = 4'b0000;
    endcase
    for (int i = 0; i < 4; i++) begin
      w_merged[8*i +: 8] = w_be[i] ? w_wdata_sh[8*i +: 8] : w_rd_word[8*i +: 8];
    end
  end

  load_align u_load_align (
    .i_word     (w_rd_word),
    .i_lane     (w_lane),
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .o_result   (w_load_data)
  );

  // The array is never reset; an async reset drops the FSM out of WAIT first.
  always_ff @(posedge Clk) begin
    if (w_access && r_write && !w_err) begin
      r_mem[w_idx] <= w_merged;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 4'd0;
      r_write    <= 1'b0;
      r_size     <= SZ_WORD;
      r_unsigned <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= 32'd0;
      Ack        <= 1'b0;
      RData      <= 32'd0;
      Err        <= 1'b0;
      Busy       <= 1'b0;
    end else begin
      Ack <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (Req) begin
            r_write    <= Write;
            r_size     <= Size;
            r_unsigned <= Unsigned;
            r_addr     <= Addr;
            r_wdata    <= WData;
            r_cnt      <= c_cnt_init;
            Busy       <= 1'b1;
            r_state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            Ack     <= 1'b1;
            Err     <= w_err;
            RData   <= (w_err || r_write) ? 32'd0 : w_load_data;
            r_state <= ST_RESP;
          end
        end
        ST_RESP: begin
          Busy    <= 1'b0;
          RData   <= 32'd0;
          Err     <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_responder
// Description : Scoreboard bench with a byte-array reference model.
// Revision    : 1.0
// ============================================================================
module tb_data_mem_responder;
  import dmem_pkg::*;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, wr, uns, ack, err, busy;
  logic [1:0]  sz;
  logic [31:0] addr, wdata, rdata;
  logic        req1, ack1, err1, busy1;
  logic [31:0] rdata1;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] rd;
    logic        er;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  logic [7:0] mbytes [0:4095];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_mem_responder #(.ADDR_W(10), .LATENCY(LAT), .BYTE_ADDR_W(32)) u_dut (
    .Clk(clk), .Reset(rst_n), .Req(req), .Write(wr), .Size(sz), .Unsigned(uns),
    .Addr(addr), .WData(wdata), .Ack(ack), .RData(rdata), .Err(err), .Busy(busy)
  );

  data_mem_responder #(.ADDR_W(10), .LATENCY(1), .BYTE_ADDR_W(32)) u_dut_l1 (
    .Clk(clk), .Reset(rst_n), .Req(req1), .Write(1'b1), .Size(SZ_WORD), .Unsigned(1'b0),
    .Addr(32'd0), .WData(32'd0), .Ack(ack1), .RData(rdata1), .Err(err1), .Busy(busy1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Reference: byte-addressed memory, lane count from size, arithmetic extension.
  function automatic void model(input logic w, input logic [1:0] s, input logic u,
                                input logic [31:0] a, input logic [31:0] wd,
                                output logic [31:0] rd, output logic er);
    int     n;
    longint v;
    er = (s == 2'd3) || (s == 2'd1 && a % 2 != 0) || (s == 2'd0 && a % 4 != 0) || (a >= 4096);
    rd = 32'd0;
    if (er) return;
    n = (s == 2'd0) ? 4 : (s == 2'd1) ? 2 : 1;
    if (w) begin
      for (int i = 0; i < n; i++) mbytes[a + i] = wd[8*i +: 8];
    end else begin
      v = 0;
      for (int i = 0; i < n; i++) v += longint'(mbytes[a + i]) << (8 * i);
      if (!u && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= (longint'(1) << (8 * n));
      rd = v[31:0];
    end
  endfunction

  // Ack is expected after the LAT-th edge following the accepting edge.
  task automatic issue(input logic w, input logic [1:0] s, input logic u,
                       input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    int   t;
    @(negedge clk);
    wr = w; sz = s; uns = u; addr = a; wdata = wd; req = 1'b1;
    model(w, s, u, a, wd, e.rd, e.er);
    @(posedge clk);
    e.cyc = cyc + LAT + 1;
    exp_q.push_back(e);
    @(negedge clk);
    chk("busy_after_accept", busy, 1);
    t = 0;
    while (!ack && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (!ack) begin
      n_checks++; n_errors++;
      $display("FAIL ack_timeout: got no Ack expected Ack within 40 cycles");
    end
    req = 1'b0;
    @(negedge clk);
    chk("busy_after_ack", busy, 0);
  endtask

  logic prev_ack = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (ack) begin
      chk("ack_no_back2back", prev_ack, 0);
      chk("busy_with_ack", busy, 1);
      if (exp_q.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL unexpected_ack: got Ack expected none");
      end else begin
        e = exp_q.pop_front();
        chk("ack_cycle", cyc, e.cyc);
        chk("ack_rdata", rdata, e.rd);
        chk("ack_err", err, e.er);
      end
    end else begin
      chk("idle_rdata_err", {rdata[31:1], rdata[0] | err}, 0);
    end
    prev_ack = ack;
  end

  initial begin
    exp_t e;
    int t, k, e0;
    logic prev;
    logic w, u;
    logic [1:0] s;
    logic [31:0] a;
    rst_n = 1'b0; req = 1'b0; req1 = 1'b0;
    wr = 1'b0; sz = 2'b00; uns = 1'b0; addr = 32'd0; wdata = 32'd0;
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_ack", ack, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) issue(1'b1, SZ_WORD, 1'b0, 32'(i * 4), $urandom);

    issue(1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF);
    issue(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0);
    issue(1'b0, SZ_BYTE, 1'b1, 32'h11, 32'h0);
    issue(1'b0, SZ_BYTE, 1'b0, 32'h13, 32'h0);
    issue(1'b0, SZ_BYTE, 1'b0, 32'h12, 32'h0);
    issue(1'b1, SZ_HALF, 1'b0, 32'h12, 32'h1234);
    issue(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0);
    issue(1'b0, SZ_HALF, 1'b0, 32'h10, 32'h0);

    issue(1'b1, SZ_HALF, 1'b0, 32'h11, 32'hFFFF);
    issue(1'b0, SZ_WORD, 1'b0, 32'h12, 32'h0);
    issue(1'b1, 2'b11,   1'b0, 32'h10, 32'hFFFFFFFF);
    issue(1'b1, SZ_WORD, 1'b0, 32'h1000, 32'h55555555);
    issue(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0);

    // Abort a store in WAIT: the model is not updated.
    @(negedge clk);
    wr = 1'b1; sz = SZ_WORD; uns = 1'b0; addr = 32'h20; wdata = 32'hCAFEF00D; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_ack", ack, 0);
    repeat (4) begin
      @(negedge clk);
      chk("abort_no_ack", ack, 0);
    end
    rst_n = 1'b1;
    issue(1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0);

    // Req held: four back-to-back loads, accepts LAT+2 apart.
    @(negedge clk);
    wr = 1'b0; sz = SZ_WORD; uns = 1'b0; addr = 32'h10; req = 1'b1;
    @(posedge clk);
    e0 = cyc;
    for (int i = 0; i < 4; i++) begin
      model(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, e.rd, e.er);
      e.cyc = e0 + i * (LAT + 2) + LAT + 1;
      exp_q.push_back(e);
    end
    k = 0; t = 0;
    while (k < 4 && t < 100) begin
      @(negedge clk);
      t++;
      if (ack) k++;
    end
    req = 1'b0;
    chk("held_ack_count", k, 4);
    @(negedge clk);

    for (int i = 0; i < 150; i++) begin
      w = 1'($urandom_range(0, 1));
      s = 2'($urandom_range(0, 3));
      u = 1'($urandom_range(0, 1));
      a = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 15) == 0) a = a | (32'd1 << $urandom_range(12, 31));
      issue(w, s, u, a, $urandom);
    end

    // LATENCY=1 instance with Req held: Ack 2 edges after accept, every 3 cycles.
    @(negedge clk);
    req1 = 1'b1;
    @(posedge clk);
    e0 = cyc;
    k = 0; t = 0; prev = 1'b0;
    while (k < 3 && t < 60) begin
      @(negedge clk);
      t++;
      if (ack1) begin
        chk("l1_ack_cycle", cyc, e0 + k * 3 + 2);
        chk("l1_err", err1, 0);
        chk("l1_rdata", rdata1, 0);
        chk("l1_busy", busy1, 1);
        chk("l1_no_back2back", prev, 0);
        k++;
      end
      prev = ack1;
    end
    req1 = 1'b0;
    chk("l1_ack_count", k, 3);

    t = 0;
    while (exp_q.size() != 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("scoreboard_drained", exp_q.size(), 0);
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the pipeline's load/store port: the slave end of a req/ack data-memory handshake, replacing the zero-latency combinational data memory.
- Accepts one word, half or byte request at a time, waits a programmable number of cycles, then performs the access and returns aligned, extended read data or a write completion with a one-cycle Ack.
- Sits between the MEM stage (initiator, stalls on !Ack) and the data-memory array it owns internally.

Parameters:
- ADDR_W, 10, word-address bits; array depth is 2**ADDR_W 32-bit words.
- LATENCY, 2, cycles from accept to access; legal range 1..15.
- BYTE_ADDR_W, 32, width of the Addr port.

Ports:
- Clk  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-low reset.
- Req  in  1  request valid; held with all request fields stable until Ack.
- Write  in  1  1 = store, 0 = load.
- Size  in  2  00 word, 01 half, 10 byte, 11 reserved.
- Unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- Addr  in  BYTE_ADDR_W  byte address.
- WData  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
- Ack  out  1  one-cycle completion pulse.
- RData  out  32  load result; valid while Ack=1, 0 otherwise.
- Err  out  1  valid with Ack: misaligned, out-of-range or reserved-size request.
- Busy  out  1  high from accept until the Ack cycle, inclusive.

Behaviour:
- States: IDLE, WAIT, RESP; 4-bit down-counter Cnt.
- Reset (async, Reset=0): state=IDLE, Cnt=0, Ack=0, RData=0, Err=0, Busy=0. The array is not cleared. Takes effect immediately, including mid-WAIT: no write is performed and no Ack is issued for the aborted request.
- IDLE: Req=1 at a rising edge accepts the request: fields captured, Cnt=LATENCY-1, goto WAIT, Busy=1.
- WAIT, Cnt!=0: decrement Cnt.
- WAIT, Cnt==0: perform the access using the captured fields, register RData/Err, goto RESP.
- RESP: Ack=1, Busy=1 for exactly one cycle. Req is ignored in this cycle. Next state is IDLE.
- Timing: Ack is high in the cycle LATENCY+1 clocks after the accepting edge. Minimum request spacing is LATENCY+2 cycles.
- The requester may drop Req only after seeing Ack. Changes to Req or fields during WAIT are ignored.
- Addressing: word index = Addr[ADDR_W+1:2]; byte lane = Addr[1:0], little-endian (lane 0 = bits [7:0]).
- Err=1 on any of these:
  - Size=11.
  - Size=01 with Addr[0]=1.
  - Size=00 with Addr[1:0]!=0.
  - Any Addr bit above ADDR_W+1 set.
- On Err: no write, RData=0, Ack still pulses.
- Store: only the addressed byte or half lanes are updated; the other lanes keep their value. RData=0 on store Ack.
- Load: extract the lane, then sign- or zero-extend to 32 bits per Unsigned. A word load ignores Unsigned.
- Read-after-write: a load after a store to the same word returns the new data, because accesses are strictly serialized.

Decomposition:
- Shared package dmem_pkg:
  - size encodings SZ_WORD=2'b00, SZ_HALF=2'b01, SZ_BYTE=2'b10;
  - state encoding for IDLE/WAIT/RESP;
  - LATENCY legality bound (15).
- One combinational sub-module, load_align: (word, Addr[1:0], Size, Unsigned) -> 32-bit extended result. It is reused by the core's own load path.
- The byte-enable merge for stores stays inline.

Test Plan:
- LATENCY=2, reset released: store word 0xDEADBEEF to Addr 0x10 -> Ack high 3 cycles after the accepting edge, Err=0, RData=0. Then a word load from 0x10 -> RData=0xDEADBEEF.
- After the above, byte loads:
  - Addr 0x11, Unsigned=1 -> 0x000000BE;
  - Addr 0x13, Unsigned=0 -> 0xFFFFFFDE;
  - Addr 0x12, Unsigned=0 -> 0xFFFFFFAD.
- Store half 0x1234 to Addr 0x12 -> word load from 0x10 returns 0x1234BEEF. Half load from 0x10, Unsigned=0 -> 0xFFFFBEEF.
- Error cases, each -> Ack with Err=1, RData=0, memory unchanged (word load from 0x10 still 0x1234BEEF):
  - half store at Addr 0x11;
  - word load at Addr 0x12;
  - Size=11;
  - Addr = 1<<(ADDR_W+2).
- Reset mid-operation: accept a store of 0xCAFEF00D to Addr 0x20, pulse Reset low during WAIT -> no Ack, Busy=0 immediately, and a later word load from 0x20 returns the prior value.
- Req held high continuously: Acks exactly LATENCY+2 cycles apart, one per access, never two consecutive Ack cycles. With LATENCY=1, Ack occurs 2 cycles after accept.
